// File: rtl/hazard_scoreboard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard scoreboard.
// Holds forwarding codes, Tuse/Tnew encodings and the per-stage writer record.
package hazard_scoreboard_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned TNEW_W = 2;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0]  FWD_GRF = 2'd0;
    localparam logic [SEL_W-1:0]  FWD_E   = 2'd1;
    localparam logic [SEL_W-1:0]  FWD_M   = 2'd2;
    localparam logic [SEL_W-1:0]  FWD_W   = 2'd3;

    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;
    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  wa;
        logic [TNEW_W-1:0] tnew;
    } slot_t;

    // Advance a record by one stage: tnew counts down and sticks at zero.
    function automatic slot_t age_slot(input slot_t s);
        slot_t r;
        r = s;
        if (s.tnew != '0) begin
            r.tnew = s.tnew - TNEW_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_ctrl_if.sv
// D-stage request / hazard-response bundle between the decode stage and the hazard controller.
interface hazard_scoreboard_ctrl_if;
    import hazard_scoreboard_ctrl_pkg::*;

    logic              d_valid;
    logic [REG_W-1:0]  d_rs;
    logic [REG_W-1:0]  d_rt;
    logic [TNEW_W-1:0] d_tuse_rs;
    logic [TNEW_W-1:0] d_tuse_rt;
    logic [REG_W-1:0]  d_wa;
    logic [TNEW_W-1:0] d_tnew;
    logic              d_md_start;
    logic              d_md_is_div;
    logic              d_md_use;

    logic              stall;
    logic              e_bubble;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic              md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_md_is_div, d_md_use,
        input  stall, e_bubble, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_md_is_div, d_md_use,
        output stall, e_bubble, fwd_rs_sel, fwd_rt_sel, md_busy
    );

endinterface

// File: rtl/hazard_src_check.sv
// Resolves one D-stage source operand against the E/M/W writer records.
// Nearest matching stage wins; it either forwards (tnew 0) or demands a stall (tnew > tuse).
module hazard_src_check
    import hazard_scoreboard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0]  src,
    input  logic [TNEW_W-1:0] tuse,
    input  slot_t             slot_e,
    input  slot_t             slot_m,
    input  slot_t             slot_w,
    output logic              stall_src_c,
    output logic [SEL_W-1:0]  fwd_sel_c
);

    logic              used_c;
    logic              hit_e_c;
    logic              hit_m_c;
    logic              hit_w_c;
    logic              hit_c;
    logic [TNEW_W-1:0] tnew_c;
    logic [SEL_W-1:0]  code_c;

    assign used_c  = (src != '0) && (tuse != TUSE_NONE);
    assign hit_e_c = used_c && slot_e.valid && (slot_e.wa == src);
    assign hit_m_c = used_c && slot_m.valid && (slot_m.wa == src);
    assign hit_w_c = used_c && slot_w.valid && (slot_w.wa == src);

    // Priority select of the youngest writer; older matches are shadowed.
    always_comb begin
        hit_c  = 1'b0;
        tnew_c = '0;
        code_c = FWD_GRF;
        if (hit_e_c) begin
            hit_c  = 1'b1;
            tnew_c = slot_e.tnew;
            code_c = FWD_E;
        end else if (hit_m_c) begin
            hit_c  = 1'b1;
            tnew_c = slot_m.tnew;
            code_c = FWD_M;
        end else if (hit_w_c) begin
            hit_c  = 1'b1;
            tnew_c = slot_w.tnew;
            code_c = FWD_W;
        end
    end

    assign stall_src_c = hit_c && (tnew_c > tuse);
    assign fwd_sel_c   = (hit_c && (tnew_c == '0)) ? code_c : FWD_GRF;

endmodule

// File: rtl/hazard_scoreboard_ctrl.sv
// Central hazard controller: E/M/W writer scoreboard, stall/bubble generation,
// D-stage forwarding selects and the mult/div busy window.
module hazard_scoreboard_ctrl
    import hazard_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hazard_scoreboard_ctrl_if.slave hif
);

    slot_t             slot_e_q, slot_e_d;
    slot_t             slot_m_q, slot_m_d;
    slot_t             slot_w_q, slot_w_d;
    logic              e_md_q, e_md_d;
    logic              e_md_div_q, e_md_div_d;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;

    logic              stall_rs_c, stall_rt_c;
    logic [SEL_W-1:0]  fwd_rs_c, fwd_rt_c;
    logic              md_busy_c;
    logic              md_stall_c;
    logic              stall_c;
    logic              issue_c;

    hazard_src_check u_rs_check (
        .src         (hif.d_rs),
        .tuse        (hif.d_tuse_rs),
        .slot_e      (slot_e_q),
        .slot_m      (slot_m_q),
        .slot_w      (slot_w_q),
        .stall_src_c (stall_rs_c),
        .fwd_sel_c   (fwd_rs_c)
    );

    hazard_src_check u_rt_check (
        .src         (hif.d_rt),
        .tuse        (hif.d_tuse_rt),
        .slot_e      (slot_e_q),
        .slot_m      (slot_m_q),
        .slot_w      (slot_w_q),
        .stall_src_c (stall_rt_c),
        .fwd_sel_c   (fwd_rt_c)
    );

    // An md start sitting in E has not loaded the counter yet, so it counts as busy too.
    assign md_busy_c  = (md_cnt_q != '0) || e_md_q;
    assign md_stall_c = hif.d_md_use && md_busy_c;
    assign stall_c    = hif.d_valid && (stall_rs_c || stall_rt_c || md_stall_c);
    assign issue_c    = hif.d_valid && !stall_c;

    always_comb begin
        slot_m_d   = age_slot(slot_e_q);
        slot_w_d   = age_slot(slot_m_q);
        slot_e_d   = '0;
        e_md_d     = 1'b0;
        e_md_div_d = 1'b0;
        md_cnt_d   = md_cnt_q;

        if (issue_c) begin
            slot_e_d.valid = (hif.d_wa != '0);
            slot_e_d.wa    = hif.d_wa;
            slot_e_d.tnew  = hif.d_tnew;
            e_md_d         = hif.d_md_start;
            e_md_div_d     = hif.d_md_start && hif.d_md_is_div;
        end

        if (e_md_q) begin
            md_cnt_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_e_q   <= '0;
            slot_m_q   <= '0;
            slot_w_q   <= '0;
            e_md_q     <= 1'b0;
            e_md_div_q <= 1'b0;
            md_cnt_q   <= '0;
        end else begin
            slot_e_q   <= slot_e_d;
            slot_m_q   <= slot_m_d;
            slot_w_q   <= slot_w_d;
            e_md_q     <= e_md_d;
            e_md_div_q <= e_md_div_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    assign hif.stall      = stall_c;
    assign hif.e_bubble   = stall_c;
    assign hif.fwd_rs_sel = fwd_rs_c;
    assign hif.fwd_rt_sel = fwd_rt_c;
    assign hif.md_busy    = md_busy_c;

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl: load-use, branch-use, shadowing,
// $0 writes, mult/div busy windows and asynchronous reset mid-stall.
module tb_hazard_scoreboard_ctrl;

    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_scoreboard_ctrl_if hif ();

    hazard_scoreboard_ctrl #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hif     (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] trs, input logic [1:0] trt,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic mds, input logic mdd, input logic mdu);
        hif.d_valid     = v;
        hif.d_rs        = rs;
        hif.d_rt        = rt;
        hif.d_tuse_rs   = trs;
        hif.d_tuse_rt   = trt;
        hif.d_wa        = wa;
        hif.d_tnew      = tn;
        hif.d_md_start  = mds;
        hif.d_md_is_div = mdd;
        hif.d_md_use    = mdu;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 5'd1, 5'd2, 2'd0, 2'd0, 5'd3, 2'd1, 1'b0, 1'b0, 1'b1);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", hif.stall); end
        checks++; if (hif.e_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble got %b want 0", hif.e_bubble); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL rst_fwd_rs got %0d want 0", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL rst_fwd_rt got %0d want 0", hif.fwd_rt_sel); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy got %b want 0", hif.md_busy); end
        repeat (2) step();
        #2 reset_n = 1'b1;
        idle(2);
    endtask

    // lw $1 then addu $2,$1,$3 (rs consumed in E)
    task automatic test_load_use();
        idle(12);
        drive(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall got %b want 0", hif.stall); end
        step();
        drive(1'b1, 5'd1, 5'd3, 2'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL lu_stall1 got %b want 1", hif.stall); end
        checks++; if (hif.e_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble1 got %b want 1", hif.e_bubble); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL lu_fwd1 got %0d want 0", hif.fwd_rs_sel); end
        step();
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_stall2 got %b want 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL lu_fwd2 got %0d want 0", hif.fwd_rs_sel); end
        step();
        // lw now in W with tnew 0; a later reader of $1 picks it up from W
        drive(1'b1, 5'd1, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.fwd_rs_sel !== 2'd3) begin errors++; $display("FAIL lu_fwd3 got %0d want 3", hif.fwd_rs_sel); end
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_stall3 got %b want 0", hif.stall); end
    endtask

    // lw $1 then beq $1,$0 (rs consumed in D)
    task automatic test_branch_use();
        idle(4);
        drive(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL br_stall1 got %b want 1", hif.stall); end
        step();
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL br_stall2 got %b want 1", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL br_fwd2 got %0d want 0", hif.fwd_rs_sel); end
        step();
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL br_stall3 got %b want 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== 2'd3) begin errors++; $display("FAIL br_fwd3 got %0d want 3", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL br_fwd_rt3 got %0d want 0", hif.fwd_rt_sel); end
    endtask

    // two writers of $4; the younger one shadows the older
    task automatic test_shadow();
        idle(4);
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL sh_stall0 got %b want 0", hif.stall); end
        step();
        drive(1'b1, 5'd4, 5'd4, 2'd0, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL sh_stall1 got %b want 1", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL sh_fwd_rs1 got %0d want 0", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL sh_fwd_rt1 got %0d want 0", hif.fwd_rt_sel); end
        step();
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL sh_stall2 got %b want 0", hif.stall); end
        checks++; if (hif.fwd_rs_sel !== 2'd2) begin errors++; $display("FAIL sh_fwd_rs2 got %0d want 2", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== 2'd2) begin errors++; $display("FAIL sh_fwd_rt2 got %0d want 2", hif.fwd_rt_sel); end
    endtask

    task automatic test_zero_reg();
        idle(4);
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL zr_stall[%0d] got %b want 0", i, hif.stall); end
            checks++; if ((hif.fwd_rs_sel | hif.fwd_rt_sel) !== 2'd0) begin errors++; $display("FAIL zr_fwd[%0d] got %0d/%0d want 0/0", i, hif.fwd_rs_sel, hif.fwd_rt_sel); end
            step();
        end
    endtask

    // md start followed immediately by an mfhi; count the stalled cycles
    task automatic test_md(input logic is_div, input int exp_stalls);
        int n;
        idle(12);
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
        checks++; if (hif.stall !== 1'b0 || hif.md_busy !== 1'b0) begin errors++; $display("FAIL md_issue div=%b got stall=%b busy=%b want 0/0", is_div, hif.stall, hif.md_busy); end
        step();
        drive(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0, 1'b0, 1'b1);
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_rise div=%b got %b want 1", is_div, hif.md_busy); end
        n = 0;
        while (hif.stall === 1'b1 && n < 30) begin
            n++;
            step();
        end
        checks++; if (n != exp_stalls) begin errors++; $display("FAIL md_stall_len div=%b got %0d want %0d", is_div, n, exp_stalls); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL md_busy_end div=%b got %b want 0", is_div, hif.md_busy); end
    endtask

    task automatic test_reset_mid();
        idle(12);
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd7, 2'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 5'd1, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL rm_pre_stall got %b want 1", hif.stall); end
        checks++; if (hif.fwd_rt_sel !== 2'd2) begin errors++; $display("FAIL rm_pre_fwd_rt got %0d want 2", hif.fwd_rt_sel); end
        checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL rm_pre_busy got %b want 1", hif.md_busy); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b want 0", hif.stall); end
        checks++; if (hif.e_bubble !== 1'b0) begin errors++; $display("FAIL rm_bubble got %b want 0", hif.e_bubble); end
        checks++; if (hif.fwd_rs_sel !== 2'd0) begin errors++; $display("FAIL rm_fwd_rs got %0d want 0", hif.fwd_rs_sel); end
        checks++; if (hif.fwd_rt_sel !== 2'd0) begin errors++; $display("FAIL rm_fwd_rt got %0d want 0", hif.fwd_rt_sel); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b want 0", hif.md_busy); end
        #1 reset_n = 1'b1;
        step();
        checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rm_post_stall got %b want 0", hif.stall); end
        checks++; if ((hif.fwd_rs_sel | hif.fwd_rt_sel) !== 2'd0) begin errors++; $display("FAIL rm_post_fwd got %0d/%0d want 0/0", hif.fwd_rs_sel, hif.fwd_rt_sel); end
        checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rm_post_busy got %b want 0", hif.md_busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_use();
        test_branch_use();
        test_shadow();
        test_zero_reg();
        test_md(1'b0, 1 + MULT_CYCLES);
        test_md(1'b1, 1 + DIV_CYCLES);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
